alu_share_scheduler: RTL and testbench

Shares one ALU_32_Bit instance among NUM_REQ independent requesters.
- Each requester presents an operand pair plus a 2-bit ALU control on a valid/ready request port.
- The block grants requesters round-robin, registers the winner's operands, drives the ALU and captures Result/ALUFlags.
- The result is returned on a single tagged valid/ready response port.
- It sits between datapath clients (e.g. a multi-issue sequencer or test host) and the shared combinational ALU.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/ALU_32_Bit.sv | 34 +++
 rtl/rr_arbiter.sv | 31 +++
 rtl/alu_share_scheduler.sv | 121 ++++++++++++
 tb/tb_alu_share_scheduler.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU share scheduler: ALU op encodings, flag bit
// positions and the scheduler FSM state type.
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } sched_state_e;

endpackage

// File: rtl/ALU_32_Bit.sv
// Combinational 32-bit ALU: ADD/SUB/AND/OR with {N,Z,C,V} flags.
// SUB is A + ~B + 1, so its carry-out reads as "no borrow".
module ALU_32_Bit (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [1:0]  ALUControl,
  output logic [31:0] Result,
  output logic [3:0]  ALUFlags
);

  logic        is_sub;
  logic        is_arith;
  logic [31:0] b_eff;
  logic [32:0] sum;
  logic        carry;
  logic        ovf;

  always_comb begin
    is_sub   = (ALUControl == 2'b01);
    is_arith = ~ALUControl[1];
    b_eff    = is_sub ? ~B : B;
    sum      = {1'b0, A} + {1'b0, b_eff} + {32'd0, is_sub};
    case (ALUControl)
      2'b10:   Result = A & B;
      2'b11:   Result = A | B;
      default: Result = sum[31:0];
    endcase
    carry    = is_arith & sum[32];
    // Overflow: operands (as seen by the adder) agree in sign, result does not.
    ovf      = is_arith & (A[31] == b_eff[31]) & (sum[31] != A[31]);
    ALUFlags = {Result[31], (Result == 32'd0), carry, ovf};
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or above the
// pointer, wrapping around, wins.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_idx_o,
  output logic               any_req_o
);

  int unsigned idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_req_o = 1'b0;
    idx       = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr_i) + off) % NUM_REQ;
      if (!any_req_o && req_i[idx]) begin
        any_req_o  = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_share_scheduler.sv
// Time-shares one ALU_32_Bit among NUM_REQ requesters: round-robin grant in
// IDLE, one EXEC cycle on registered operands, tagged response held in RESP.
module alu_share_scheduler
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ),
  parameter int unsigned DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      nRESET,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_A,
  input  logic [NUM_REQ*DATA_W-1:0] req_B,
  input  logic [NUM_REQ*2-1:0]      req_ALUControl,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_Result,
  output logic [3:0]                rsp_ALUFlags,
  output logic                      busy
);

  sched_state_e state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    tag_q;
  logic [DATA_W-1:0]  a_q, b_q;
  logic [1:0]         ctrl_q;
  logic [DATA_W-1:0]  result_q;
  logic [3:0]         flags_q;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               any_req;
  logic               load_req;
  logic               capture;
  logic [DATA_W-1:0]  alu_result;
  logic [3:0]         alu_flags;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i     (req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_req_o (any_req)
  );

  ALU_32_Bit u_alu (
    .A          (a_q),
    .B          (b_q),
    .ALUControl (ctrl_q),
    .Result     (alu_result),
    .ALUFlags   (alu_flags)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    load_req = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          load_req = 1'b1;
          state_d  = StExec;
        end
      end
      StExec: begin
        capture = 1'b1;
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          // Pointer moves only on a completed response, just past the owner.
          rr_ptr_d = (tag_q == ID_W'(NUM_REQ - 1)) ? '0 : tag_q + 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      tag_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      if (load_req) begin
        a_q    <= req_A[gnt_idx*DATA_W +: DATA_W];
        b_q    <= req_B[gnt_idx*DATA_W +: DATA_W];
        ctrl_q <= req_ALUControl[gnt_idx*2 +: 2];
        tag_q  <= gnt_idx;
      end
      if (capture) begin
        result_q <= alu_result;
        flags_q  <= alu_flags;
      end
    end
  end

  // Ready is masked while reset is held so nothing looks accepted during reset.
  assign req_ready    = (state_q == StIdle && nRESET) ? gnt : '0;
  assign rsp_valid    = (state_q == StResp);
  assign rsp_id       = tag_q;
  assign rsp_Result   = result_q;
  assign rsp_ALUFlags = flags_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_alu_share_scheduler.sv
// Directed bench for alu_share_scheduler: latency, flags, round-robin order,
// backpressure, asynchronous reset and skip-on-drop behaviour.
module tb_alu_share_scheduler;
  import alu_pkg::*;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;

  logic                 clk;
  logic                 nRESET;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*32-1:0] req_A;
  logic [NUM_REQ*32-1:0] req_B;
  logic [NUM_REQ*2-1:0] req_ALUControl;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [31:0]          rsp_Result;
  logic [3:0]           rsp_ALUFlags;
  logic                 busy;

  int n_checks = 0;
  int n_pass   = 0;

  alu_share_scheduler #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .DATA_W  (32)
  ) dut (
    .clk            (clk),
    .nRESET         (nRESET),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_A          (req_A),
    .req_B          (req_B),
    .req_ALUControl (req_ALUControl),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_id         (rsp_id),
    .rsp_Result     (rsp_Result),
    .rsp_ALUFlags   (rsp_ALUFlags),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h required %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op);
    req_A[32*i +: 32]        = a;
    req_B[32*i +: 32]        = b;
    req_ALUControl[2*i +: 2] = op;
    req_valid[i]             = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ":busy"}, busy, 0);
    check_eq({tag, ":rsp_valid"}, rsp_valid, 0);
    check_eq({tag, ":req_ready"}, req_ready, 0);
    check_eq({tag, ":result"}, rsp_Result, 0);
    check_eq({tag, ":flags"}, rsp_ALUFlags, 0);
    check_eq({tag, ":id"}, rsp_id, 0);
  endtask

  // Waits (bounded) for a grant, then checks the exact 2-cycle latency and response.
  task automatic grant_and_respond(input string tag, input int g, input logic [3:0] drop,
                                   input logic [31:0] res, input logic [3:0] flg);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (req_ready != '0) seen = 1'b1;
      else begin
        @(negedge clk);
        #1;
      end
    end
    check_eq({tag, ":grant"}, req_ready, 32'(1) << g);
    @(negedge clk);
    req_valid = req_valid & ~drop;
    #1;
    check_eq({tag, ":exec_busy"}, busy, 1);
    check_eq({tag, ":exec_no_rsp"}, rsp_valid, 0);
    @(negedge clk);
    #1;
    check_eq({tag, ":rsp_valid"}, rsp_valid, 1);
    check_eq({tag, ":rsp_id"}, rsp_id, g);
    check_eq({tag, ":result"}, rsp_Result, res);
    check_eq({tag, ":flags"}, rsp_ALUFlags, flg);
  endtask

  int          t3_g   [5] = '{0, 1, 2, 3, 0};
  logic [31:0] t3_res [5] = '{32'h0000_0110, 32'h020F_FF00, 32'h8000_0000,
                              32'hFFFF_FFFF, 32'h0000_0110};
  logic [3:0]  t3_flg [5] = '{4'b0000, 4'b0000, 4'b1001, 4'b1000, 4'b0000};

  initial begin
    nRESET         = 1'b1;
    req_valid      = '0;
    req_A          = '0;
    req_B          = '0;
    req_ALUControl = '0;
    rsp_ready      = 1'b1;
    #3;
    nRESET = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    nRESET = 1'b1;

    // Single requester ADD, exact latency.
    set_req(0, 32'h0000_1000, 32'h1010_0010, ALU_ADD);
    #1;
    grant_and_respond("t1", 0, 4'b0001, 32'h1010_1010, 4'b0000);

    // SUB to zero with carry, then ADD with carry and negative result.
    set_req(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ALU_SUB);
    grant_and_respond("t2a", 2, 4'b0100, 32'h0000_0000, 4'b0110);
    set_req(1, 32'hFFFF_FFFF, 32'hFF00_0000, ALU_ADD);
    grant_and_respond("t2b", 1, 4'b0010, 32'hFEFF_FFFF, 4'b1010);

    // All four valid from reset: round-robin 0,1,2,3,0.
    @(negedge clk);
    nRESET = 1'b0;
    set_req(0, 32'h0010_0110, 32'h000F_FFF0, ALU_AND);
    set_req(1, 32'h0004_0100, 32'h020F_FF00, ALU_OR);
    set_req(2, 32'h7FFF_FFFF, 32'h0000_0001, ALU_ADD);
    set_req(3, 32'h0000_0001, 32'h0000_0002, ALU_SUB);
    @(negedge clk);
    nRESET = 1'b1;
    #1;
    for (int k = 0; k < 5; k++)
      grant_and_respond($sformatf("t3_%0d", k), t3_g[k], (k == 4) ? 4'hF : 4'h0,
                        t3_res[k], t3_flg[k]);

    // Backpressure: pointer now at 1, so requester 1 wins; requester 2 waits.
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req(1, 32'h0000_0005, 32'h0000_0007, ALU_ADD);
    set_req(2, 32'h0000_0001, 32'h0000_0001, ALU_ADD);
    #1;
    check_eq("t4:grant", req_ready, 4'b0010);
    @(negedge clk);
    req_valid[1]     = 1'b0;
    req_A[32 +: 32]  = 32'hDEAD_BEEF;
    @(negedge clk);
    #1;
    check_eq("t4:rsp_valid", rsp_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 5) req_valid[2] = 1'b0;
      #1;
      check_eq($sformatf("t4_hold%0d:rsp_valid", i), rsp_valid, 1);
      check_eq($sformatf("t4_hold%0d:result", i), rsp_Result, 32'h0000_000C);
      check_eq($sformatf("t4_hold%0d:id", i), rsp_id, 1);
      check_eq($sformatf("t4_hold%0d:req_ready", i), req_ready, 0);
      check_eq($sformatf("t4_hold%0d:busy", i), busy, 1);
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check_eq($sformatf("t4_after%0d:rsp_valid", i), rsp_valid, 0);
      check_eq($sformatf("t4_after%0d:busy", i), busy, 0);
    end

    // Reset during EXEC: in-flight op discarded, outputs clear immediately.
    set_req(2, 32'h0000_0001, 32'h0000_0001, ALU_ADD);
    #1;
    check_eq("t5:grant", req_ready, 4'b0100);
    @(posedge clk);
    #2;
    req_valid = '0;
    nRESET    = 1'b0;
    #1;
    check_reset_outputs("t5_rst");
    set_req(0, 32'h0004_0100, 32'h020F_FF00, ALU_OR);
    set_req(3, 32'h0000_0001, 32'h0000_0002, ALU_SUB);
    #1;
    check_eq("t5_rst:ready_masked", req_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check_eq($sformatf("t5_rst%0d:rsp_valid", i), rsp_valid, 0);
    end
    @(negedge clk);
    nRESET = 1'b1;
    #1;
    // Requester 0 first after reset; requester 3 still served despite 0 staying valid.
    grant_and_respond("t5a", 0, 4'b0000, 32'h020F_FF00, 4'b0000);
    grant_and_respond("t5b", 3, 4'b1000, 32'hFFFF_FFFF, 4'b1000);
    grant_and_respond("t5c", 0, 4'b0000, 32'h020F_FF00, 4'b0000);

    // Requester 1 withdraws before it can be granted: skipped, never readied.
    req_valid[1] = 1'b1;
    #1;
    check_eq("t6:no_ready_in_resp", req_ready, 0);
    #1;
    req_valid[1] = 1'b0;
    set_req(2, 32'h7FFF_FFFF, 32'h0000_0001, ALU_ADD);
    grant_and_respond("t6", 2, 4'b0101, 32'h8000_0000, 4'b1001);

    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
